bsg_link_ddr_core_arbiter: RTL and testbench
============================================

Name: bsg_link_ddr_core_arbiter

Overview:
- Core-clock round-robin packet arbiter. Shares one bsg_link_ddr_upstream core-side input among num_in_p requesters.
- Packets are multi-flit. Flit 0 (the header) carries a body-length field. The arbiter locks the grant for the whole packet.
- It stamps the source index into the header, so the far-side consumer of bsg_link_ddr_downstream can demultiplex by source.

Parameters:
- width_p, "inv", flit width. Must equal the paired link's core width_p.
- num_in_p, 4, number of requesters. Must be >= 2; non-power-of-two is allowed.
- len_width_p, 4, header bits [len_width_p-1:0] = number of body flits following the header (0..2^len_width_p-1).
- id_width_lp, derived: `BSG_SAFE_CLOG2(num_in_p). Header bits [len_width_p +: id_width_lp] are overwritten with the source index. Requires len_width_p+id_width_lp <= width_p.

Ports:
- core_clk_i  in  1  core clock. Single clock domain.
- core_link_reset_i  in  1  synchronous, active-high reset.
- core_data_i  in  num_in_p x width_p  per-requester flit.
- core_v_i  in  num_in_p  per-requester valid. Must hold valid and data until yumi.
- core_yumi_o  out  num_in_p  one-hot-or-zero dequeue to requesters.
- core_data_o  out  width_p  flit to link. Header has the id field stamped.
- core_v_o  out  1  valid to link.
- core_ready_i  in  1  link ready.
- core_grant_id_o  out  id_width_lp  currently selected or locked source.
- core_busy_o  out  1  high in HEAD or BODY.

Behaviour:
- Handshake rules:
  - Output transfer = core_v_o & core_ready_i.
  - core_yumi_o[g] = transfer, where g is the selected source. All other yumi bits are 0.
  - Zero-cycle pass-through latency: data is combinational from the selected input, with the id field muxed in on header flits only.
- State is 2 bits: IDLE, HEAD, BODY. Registers:
  - rr_ptr_r (id_width_lp)
  - lock_id_r (id_width_lp)
  - cnt_r (len_width_p)
- Reset:
  - State IDLE, rr_ptr_r=0, lock_id_r=0, cnt_r=0.
  - While reset is high: core_v_o=0, core_yumi_o=0, core_busy_o=0, core_grant_id_o=0.
  - Reset mid-packet abandons the packet. The link is reset concurrently by the system.
- IDLE:
  - Winner = first i with core_v_i[i], searching rr_ptr_r, rr_ptr_r+1, ... mod num_in_p.
  - No valid inputs: core_v_o=0, core_grant_id_o=rr_ptr_r.
  - Winner exists: core_v_o=1 and a header is presented.
    - Transfer with len==0: stay IDLE, rr_ptr_r = winner+1 mod num_in_p.
    - Transfer with len>0: cnt_r=len, lock_id_r=winner, go BODY.
    - No transfer (ready low): lock_id_r=winner, go HEAD.
- HEAD:
  - Presents the locked source's header; the grant is not re-arbitrated even if higher-rr-order inputs become valid.
  - On transfer, follow the same len rule as IDLE, using lock_id_r.
- BODY:
  - Presents body flits of lock_id_r unmodified (no id stamping).
  - core_v_o = core_v_i[lock_id_r]. A requester bubble mid-packet gives core_v_o=0 and the lock is kept.
  - Each transfer decrements cnt_r.
  - Transfer with cnt_r==1: go IDLE, rr_ptr_r = lock_id_r+1 mod num_in_p.
- Wrap-around:
  - The pointer increment wraps at num_in_p, not at 2^id_width_lp.
  - The search skips indices >= num_in_p.
- Fairness: a continuously valid requester is granted within num_in_p packet completions.
- core_grant_id_o = winner in IDLE, lock_id_r otherwise.
- core_busy_o = (state != IDLE).
- Assertions (translate_off): one-hot-or-zero yumi; parameter width checks with $error/$finish.

Decomposition:
- No shared package needed.
- The state enum is a local typedef; id_width_lp is a localparam.
- Round-robin search goes in one sub-module: bsg_link_ddr_rr_pick. Combinational, inputs v and ptr, outputs found and idx. Instantiated once.

Test Plan:
1. All four inputs valid, single-flit headers (len=0), ready=1 → grants in order 0,1,2,3,0. Output header bits [5:4] = 0,1,2,3,0. One flit per cycle.
2. Input 1 sends len=3 while input 2 is valid; ready=1 → 4 consecutive flits from input 1, then input 2. Only the header has id=1 stamped; body flits are unmodified.
3. Header presented with ready=0 for 5 cycles while input 0 (higher rr order) becomes valid → core_data_o is stable, the grant stays locked, and input 0 is served only after the packet completes.
4. Mid-body core_v_i[lock] drops for 2 cycles → core_v_o=0 for those cycles, no other yumi, cnt_r is held, and the packet resumes.
5. num_in_p=3 with only input 2 valid, repeatedly → rr_ptr_r wraps 0→0 (2+1 mod 3), and id=2 is stamped every packet.
6. core_link_reset_i asserted in BODY with cnt_r=2 → next cycle state IDLE, rr_ptr_r=0, core_v_o=0, all yumi=0. Post-reset arbitration starts at index 0.

Source files
------------

// File: rtl/bsg_link_ddr_rr_pick.sv
// rtl/bsg_link_ddr_rr_pick.sv - round-robin search for the first valid requester at or after ptr
module bsg_link_ddr_rr_pick #(
  parameter int num_in_p   = 4,
  parameter int id_width_p = 2
) (
  input  logic [num_in_p-1:0]   v,
  input  logic [id_width_p-1:0] ptr,
  output logic                  found,
  output logic [id_width_p-1:0] idx
);

  logic [id_width_p-1:0] cand;

  // Walk from the farthest candidate back to ptr so the nearest valid one is written last and wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = '0;
    for (int k = num_in_p - 1; k >= 0; k--) begin
      cand = id_width_p'((32'(ptr) + 32'(k)) % 32'(num_in_p));
      if (v[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bsg_link_ddr_core_arbiter.sv
// rtl/bsg_link_ddr_core_arbiter.sv - packet-locked round-robin arbiter that stamps source id into headers
module bsg_link_ddr_core_arbiter #(
  parameter int width_p     = 16,
  parameter int num_in_p    = 4,
  parameter int len_width_p = 4,
  localparam int id_width_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1
) (
  input  logic                               core_clk_i,
  input  logic                               core_link_reset_i,
  input  logic [num_in_p-1:0][width_p-1:0]   core_data_i,
  input  logic [num_in_p-1:0]                core_v_i,
  output logic [num_in_p-1:0]                core_yumi_o,
  output logic [width_p-1:0]                 core_data_o,
  output logic                               core_v_o,
  input  logic                               core_ready_i,
  output logic [id_width_lp-1:0]             core_grant_id_o,
  output logic                               core_busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, HEAD = 2'd1, BODY = 2'd2} state_e;

  state_e                 state_r;
  logic [id_width_lp-1:0] rr_ptr_r, lock_id_r, winner, sel;
  logic [len_width_p-1:0] cnt_r, len;
  logic [width_p-1:0]     sel_data;
  logic                   found, sel_v, xfer;

  bsg_link_ddr_rr_pick #(
    .num_in_p  (num_in_p),
    .id_width_p(id_width_lp)
  ) pick (
    .v    (core_v_i),
    .ptr  (rr_ptr_r),
    .found(found),
    .idx  (winner)
  );

  function automatic logic [id_width_lp-1:0] next_id(input logic [id_width_lp-1:0] id);
    return (32'(id) == 32'(num_in_p - 1)) ? '0 : id + 1'b1;
  endfunction

  always_comb begin
    sel      = (state_r == IDLE) ? winner : lock_id_r;
    sel_v    = (state_r == IDLE) ? found : core_v_i[sel];
    sel_data = core_data_i[sel];
    len      = sel_data[len_width_p-1:0];
    xfer     = ~core_link_reset_i & sel_v & core_ready_i;

    core_data_o = sel_data;
    if (state_r != BODY) core_data_o[len_width_p +: id_width_lp] = sel;

    core_v_o        = ~core_link_reset_i & sel_v;
    core_grant_id_o = core_link_reset_i ? '0 : sel;
    core_busy_o     = ~core_link_reset_i & (state_r != IDLE);

    core_yumi_o = '0;
    for (int i = 0; i < num_in_p; i++) core_yumi_o[i] = xfer && (32'(sel) == 32'(i));
  end

  always_ff @(posedge core_clk_i) begin
    if (core_link_reset_i) begin
      state_r   <= IDLE;
      rr_ptr_r  <= '0;
      lock_id_r <= '0;
      cnt_r     <= '0;
    end else begin
      case (state_r)
        IDLE, HEAD: begin
          if (xfer) begin
            if (len == '0) begin
              rr_ptr_r <= next_id(sel);
              state_r  <= IDLE;
            end else begin
              cnt_r     <= len;
              lock_id_r <= sel;
              state_r   <= BODY;
            end
          end else if (state_r == IDLE && found) begin
            // Header stalled by the link: freeze the choice so later requests cannot steal it.
            lock_id_r <= winner;
            state_r   <= HEAD;
          end
        end
        BODY: begin
          if (xfer) begin
            cnt_r <= cnt_r - 1'b1;
            if (cnt_r == len_width_p'(1)) begin
              state_r  <= IDLE;
              rr_ptr_r <= next_id(lock_id_r);
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  if (num_in_p < 2) begin : g_bad_num
    $error("num_in_p must be at least 2");
  end
  if (len_width_p + id_width_lp > width_p) begin : g_bad_width
    $error("len_width_p + id_width_lp exceeds width_p");
  end

  always_ff @(posedge core_clk_i) begin
    if (!core_link_reset_i) assert ($onehot0(core_yumi_o)) else $error("core_yumi_o is not one-hot-or-zero");
  end
`endif

endmodule

// File: tb/tb_bsg_link_ddr_core_arbiter.sv
// tb/tb_bsg_link_ddr_core_arbiter.sv - self-checking bench for bsg_link_ddr_core_arbiter
module tb_bsg_link_ddr_core_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // config 0: four requesters; config 1: three requesters
  logic [3:0][7:0] d0;
  logic [3:0]      v0, y0;
  logic [7:0]      o0;
  logic            ov0, busy0, rdy0;
  logic [1:0]      gid0;
  logic [2:0][7:0] d1;
  logic [2:0]      v1, y1;
  logic [7:0]      o1;
  logic            ov1, busy1, rdy1;
  logic [1:0]      gid1;

  bsg_link_ddr_core_arbiter #(.width_p(8), .num_in_p(4), .len_width_p(4)) dut0 (
    .core_clk_i(clk), .core_link_reset_i(rst), .core_data_i(d0), .core_v_i(v0),
    .core_yumi_o(y0), .core_data_o(o0), .core_v_o(ov0), .core_ready_i(rdy0),
    .core_grant_id_o(gid0), .core_busy_o(busy0));

  bsg_link_ddr_core_arbiter #(.width_p(8), .num_in_p(3), .len_width_p(4)) dut1 (
    .core_clk_i(clk), .core_link_reset_i(rst), .core_data_i(d1), .core_v_i(v1),
    .core_yumi_o(y1), .core_data_o(o1), .core_v_o(ov1), .core_ready_i(rdy1),
    .core_grant_id_o(gid1), .core_busy_o(busy1));

  int checks = 0;
  int errors = 0;

  // requester emulation: 0 = no packet, 1 = presenting header, 2 = presenting body
  int       phase[2][4];
  int       rem[2][4];
  int       pk_left[2][4];
  int       gap[2][4];
  int       gap_at[2][4];
  int       fix_len[2][4];
  logic [7:0] cur[2][4];
  bit       acc[2][4];
  bit       rnd_mode = 1'b0;

  // reference model: packet owner and progress per config
  int m_pkt[2] = '{0, 0};
  int m_own[2] = '{0, 0};
  int m_rem[2] = '{0, 0};
  int m_ptr[2] = '{0, 0};

  int xlog0[$], xlog1[$], hlog0[$], hlog1[$];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      v0[i] = (phase[0][i] != 0) && (gap[0][i] == 0);
      d0[i] = cur[0][i];
    end
    for (int i = 0; i < 3; i++) begin
      v1[i] = (phase[1][i] != 0) && (gap[1][i] == 0);
      d1[i] = cur[1][i];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_q(input string nm, input int q[$], input int e[$]);
    chk({nm, "_count"}, q.size(), e.size());
    foreach (e[k]) chk(nm, (k < q.size()) ? q[k] : -1, e[k]);
  endtask

  task automatic model_cycle(input int c, input int n, input logic [3:0] v, input logic [3:0][7:0] d,
                             input logic [3:0] y, input logic ov, input logic [7:0] od,
                             input int gid, input logic busy, input logic rd);
    int own, l;
    bit hdr, ev, xf;
    logic [7:0] ed;
    if (rst) begin
      chk("rst_valid", int'(ov), 0);
      chk("rst_yumi", int'(y), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_grant", gid, 0);
      m_pkt[c] = 0;
      m_ptr[c] = 0;
      return;
    end
    own = -1;
    hdr = 1'b1;
    if (m_pkt[c] == 0) begin
      for (int k = 0; k < n; k++) begin
        int j;
        j = (m_ptr[c] + k) % n;
        if (own < 0 && v[j]) own = j;
      end
    end else begin
      own = m_own[c];
      hdr = (m_pkt[c] == 1);
    end
    chk("busy", int'(busy), int'(m_pkt[c] != 0));
    if (own < 0) begin
      chk("valid_idle", int'(ov), 0);
      chk("yumi_idle", int'(y), 0);
      chk("grant_idle", gid, m_ptr[c]);
      return;
    end
    ev = v[own];
    xf = ev && rd;
    chk("valid", int'(ov), int'(ev));
    chk("grant", gid, own);
    chk("yumi", int'(y), xf ? (1 << own) : 0);
    if (ev) begin
      ed = d[own];
      if (hdr) ed[5:4] = 2'(own);
      chk("data", int'(od), int'(ed));
    end
    if (ov && rd) begin
      if (c == 0) xlog0.push_back(gid); else xlog1.push_back(gid);
      if (hdr) begin
        if (c == 0) hlog0.push_back(int'(od[5:4])); else hlog1.push_back(int'(od[5:4]));
      end
    end
    if (xf) begin
      if (hdr) begin
        l = int'(d[own][3:0]);
        if (l == 0) begin
          m_pkt[c] = 0;
          m_ptr[c] = (own + 1) % n;
        end else begin
          m_pkt[c] = 2;
          m_own[c] = own;
          m_rem[c] = l;
        end
      end else begin
        m_rem[c]--;
        if (m_rem[c] == 0) begin
          m_pkt[c] = 0;
          m_ptr[c] = (own + 1) % n;
        end
      end
    end else if (m_pkt[c] == 0) begin
      m_pkt[c] = 1;
      m_own[c] = own;
    end
  endtask

  function automatic int rgap();
    if (rnd_mode && $urandom_range(0, 3) == 0) return int'($urandom_range(1, 2));
    return 0;
  endfunction

  task automatic start_hdr(input int c, input int i);
    int l;
    logic [3:0] up;
    if (fix_len[c][i] >= 0) l = fix_len[c][i];
    else if ($urandom_range(0, 3) == 0) l = int'($urandom_range(0, 15));
    else l = int'($urandom_range(0, 2));
    up = 4'($urandom_range(0, 15));
    cur[c][i] = {up, 4'(l)};
    phase[c][i] = 1;
  endtask

  task automatic finish_pkt(input int c, input int i);
    pk_left[c][i]--;
    phase[c][i] = 0;
    if (pk_left[c][i] > 0) begin
      gap[c][i] = rgap();
      if (gap[c][i] == 0) start_hdr(c, i);
    end
  endtask

  task automatic adv(input int c, input int i);
    if (acc[c][i] && phase[c][i] != 0 && gap[c][i] == 0) begin
      if (phase[c][i] == 1) begin
        if (cur[c][i][3:0] == 4'd0) finish_pkt(c, i);
        else begin
          rem[c][i] = int'(cur[c][i][3:0]);
          phase[c][i] = 2;
          cur[c][i] = 8'($urandom);
          gap[c][i] = rgap();
        end
      end else begin
        rem[c][i]--;
        if (rem[c][i] == 0) finish_pkt(c, i);
        else begin
          cur[c][i] = 8'($urandom);
          gap[c][i] = (gap_at[c][i] != 0) ? 2 : rgap();
          gap_at[c][i] = 0;
        end
      end
    end else begin
      if (gap[c][i] > 0) gap[c][i]--;
      if (phase[c][i] == 0 && gap[c][i] == 0 && pk_left[c][i] > 0) start_hdr(c, i);
    end
  endtask

  task automatic load(input int c, input int i, input int npk, input int l);
    pk_left[c][i] = npk;
    fix_len[c][i] = l;
    if (phase[c][i] == 0 && gap[c][i] == 0) start_hdr(c, i);
  endtask

  task automatic clear_all();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 4; i++) begin
        phase[c][i] = 0; rem[c][i] = 0; pk_left[c][i] = 0;
        gap[c][i] = 0; gap_at[c][i] = 0; fix_len[c][i] = -1;
        cur[c][i] = 8'h00; acc[c][i] = 1'b0;
      end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      model_cycle(0, 4, v0, d0, y0, ov0, o0, int'(gid0), busy0, rdy0);
      model_cycle(1, 3, {1'b0, v1}, {8'h00, d1}, {1'b0, y1}, ov1, o1, int'(gid1), busy1, rdy1);
      for (int i = 0; i < 4; i++) begin
        acc[0][i] = y0[i];
        acc[1][i] = (i < 3) ? y1[i] : 1'b0;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) adv(0, i);
      for (int i = 0; i < 3; i++) adv(1, i);
    end
  endtask

  task automatic clear_logs();
    xlog0.delete(); xlog1.delete(); hlog0.delete(); hlog1.delete();
  endtask

  initial begin
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    clear_all();
    cyc(3);
    #1;
    chk("reset_valid", int'(ov0), 0);
    chk("reset_yumi", int'(y0), 0);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_grant", int'(gid0), 0);
    rst = 1'b0;

    // all four requesters with single-flit packets rotate in order
    clear_logs();
    for (int i = 0; i < 4; i++) load(0, i, 2, 0);
    cyc(8);
    chk_q("t1_grants", xlog0, '{0, 1, 2, 3, 0, 1, 2, 3});
    chk_q("t1_stamp", hlog0, '{0, 1, 2, 3, 0, 1, 2, 3});

    // multi-flit packet holds the grant against a waiting requester
    clear_logs();
    load(0, 1, 1, 3);
    load(0, 2, 1, 0);
    cyc(5);
    chk_q("t2_grants", xlog0, '{1, 1, 1, 1, 2});
    chk_q("t2_stamp", hlog0, '{1, 2});

    // stalled header keeps its lock while an earlier-in-order input arrives
    clear_logs();
    rdy0 = 1'b0;
    load(0, 2, 1, 1);
    cyc(1);
    load(0, 0, 1, 0);
    cyc(3);
    #1;
    chk("t3_grant_locked", int'(gid0), 2);
    chk("t3_busy", int'(busy0), 1);
    chk("t3_valid", int'(ov0), 1);
    cyc(1);
    rdy0 = 1'b1;
    cyc(3);
    chk_q("t3_grants", xlog0, '{2, 2, 0});

    // requester bubble mid-body
    clear_logs();
    load(0, 2, 1, 3);
    gap_at[0][2] = 1;
    cyc(2);
    #1;
    chk("t4_bubble_valid", int'(ov0), 0);
    chk("t4_bubble_yumi", int'(y0), 0);
    chk("t4_bubble_busy", int'(busy0), 1);
    cyc(6);
    chk_q("t4_grants", xlog0, '{2, 2, 2, 2});

    // three requesters: pointer wraps past the last index
    clear_logs();
    load(1, 2, 3, 0);
    cyc(4);
    chk_q("t5_grants", xlog1, '{2, 2, 2});
    chk_q("t5_stamp", hlog1, '{2, 2, 2});

    // reset in the middle of a body abandons the packet and restarts arbitration at 0
    clear_logs();
    load(0, 1, 1, 5);
    cyc(4);
    #1;
    chk("t6_busy_before", int'(busy0), 1);
    rst = 1'b1;
    clear_all();
    cyc(1);
    rst = 1'b0;
    #1;
    chk("t6_valid_after", int'(ov0), 0);
    chk("t6_yumi_after", int'(y0), 0);
    chk("t6_busy_after", int'(busy0), 0);
    chk("t6_grant_after", int'(gid0), 0);
    clear_logs();
    load(0, 0, 1, 0);
    load(0, 3, 1, 0);
    cyc(2);
    chk_q("t6_grants", xlog0, '{0, 3});

    // randomized traffic, backpressure, bubbles and occasional resets on both configs
    rnd_mode = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        clear_all();
      end
      if (!rst) begin
        for (int c = 0; c < 2; c++)
          for (int i = 0; i < ((c == 0) ? 4 : 3); i++)
            if (phase[c][i] == 0 && pk_left[c][i] == 0 && gap[c][i] == 0 && $urandom_range(0, 7) == 0)
              load(c, i, int'($urandom_range(1, 3)), -1);
      end
      rdy0 = ($urandom_range(0, 3) != 0);
      rdy1 = ($urandom_range(0, 3) != 0);
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
